pe_array_acc: RTL and testbench

//  Parametrised multi-pass convolution PE array. Each beat multiplies N_PE signed
//  ifm/wgt pairs and reduces them in a registered adder tree. The tree sum is

---
 rtl/pe_arr_pkg.sv | 39 +++
 rtl/pe_adder_tree_p.sv | 47 ++++
 rtl/pe_array_acc.sv | 140 ++++++++++++++
 tb/tb_pe_array_acc.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_arr_pkg.sv
// Shared types and helpers for the multi-pass convolution PE array.
// The sideband bias field is sized to WIDE_W so one struct serves any ACC_W below it.
package pe_arr_pkg;

   localparam int WIDE_W = 64;

   typedef struct packed {
      logic                     valid;
      logic                     first;
      logic                     last;
      logic                     relu;
      logic signed [WIDE_W-1:0] bias;
   } sideband_t;

   function automatic int tree_depth(input int n);
      return $clog2(n);
   endfunction

   function automatic int pe_lat(input int n);
      return tree_depth(n) + 3;
   endfunction

   function automatic logic signed [WIDE_W-1:0] sat_signed(
      input logic signed [WIDE_W-1:0] val,
      input int                       out_w
   );
      logic signed [WIDE_W-1:0] max_v;
      logic signed [WIDE_W-1:0] min_v;
      max_v = (WIDE_W'(1) <<< (out_w - 1)) - WIDE_W'(1);
      min_v = -max_v - WIDE_W'(1);
      if (val > max_v) begin
         return max_v;
      end else if (val < min_v) begin
         return min_v;
      end
      return val;
   endfunction

endpackage

// File: rtl/pe_adder_tree_p.sv
// Registered pairwise adder tree: N signed IN_W leaves, TD register levels, +1 bit per level.
// Leaves are zero-padded to 2**TD, so an odd leftover simply adds zero and passes through registered.
module pe_adder_tree_p #(
   parameter int N    = 9,
   parameter int IN_W = 16,
   parameter int TD   = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N*IN_W-1:0]      data_i,
   output logic signed [IN_W+TD-1:0] sum_o
);

   localparam int NP    = 1 << TD;
   localparam int OW    = IN_W + TD;
   localparam int NODES = 2 * NP - 1;
   localparam int PAD_W = NP * IN_W;

   logic [PAD_W-1:0]     pad_leaves;
   logic signed [OW-1:0] node_q [NP-1];
   logic signed [OW-1:0] all_n  [NODES];

   assign pad_leaves = PAD_W'(data_i);

   // Heap layout: internal nodes 0..NP-2 are registers, leaves follow at NP-1..NODES-1.
   // NOTE: every element of all_n is assigned on every pass, so no latch can be inferred.
   always_comb begin
      for (int k = 0; k < NP - 1; k++) begin
         all_n[k] = node_q[k];
      end
      for (int j = 0; j < NP; j++) begin
         all_n[NP-1+j] = OW'(signed'(pad_leaves[j*IN_W +: IN_W]));
      end
   end

   // NOTE: the node array is real pipeline state, so it is reset like any register; use <= only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NP - 1; k++) node_q[k] <= '0;
      end else begin
         for (int k = 0; k < NP - 1; k++) node_q[k] <= all_n[2*k+1] + all_n[2*k+2];
      end
   end

   assign sum_o = all_n[0];

endmodule

// File: rtl/pe_array_acc.sv
// Multi-pass convolution PE array: multiply, registered adder tree, channel accumulator,
// then ReLU/saturation output stage. One result pulse per window, LAT = tree depth + 3.
module pe_array_acc
   import pe_arr_pkg::*;
#(
   parameter int IN_W  = 8,
   parameter int N_PE  = 9,
   parameter int ACC_W = 32,
   parameter int OUT_W = 20
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic                     in_first,
   input  logic                     in_last,
   input  logic [N_PE*IN_W-1:0]     ifm_in,
   input  logic [N_PE*IN_W-1:0]     wgt_in,
   input  logic signed [ACC_W-1:0]  bias_in,
   input  logic                     relu_en,
   output logic                     out_valid,
   output logic signed [OUT_W-1:0]  ofm_out,
   output logic                     sat_flag
);

   localparam int TD     = tree_depth(N_PE);
   localparam int PROD_W = 2 * IN_W;
   localparam int SUM_W  = PROD_W + TD;

   logic [N_PE*PROD_W-1:0]  prod_d, prod_q;
   sideband_t               sb_in;
   sideband_t               sb_q [TD+1];
   sideband_t               sb_a;
   logic signed [SUM_W-1:0] tree_sum;

   logic signed [ACC_W-1:0] acc_d, acc_q, res_q;
   logic                    res_vld_q, res_relu_q;

   logic signed [WIDE_W-1:0] relu_v, clamp_v;
   logic                     out_valid_q, sat_q;
   logic signed [OUT_W-1:0]  ofm_q;
   logic                     unused_hi;

   // ---------------- stage M: products and sideband entry ----------------
   always_comb begin
      prod_d = '0;
      for (int i = 0; i < N_PE; i++) begin
         prod_d[i*PROD_W +: PROD_W] = PROD_W'(signed'(ifm_in[i*IN_W +: IN_W]))
                                    * PROD_W'(signed'(wgt_in[i*IN_W +: IN_W]));
      end
   end

   // Control fields are zeroed on idle cycles so bubbles can never open or close a window.
   always_comb begin
      sb_in = '0;
      if (in_valid) begin
         sb_in.valid = 1'b1;
         sb_in.first = in_first;
         sb_in.last  = in_last;
         sb_in.relu  = in_last & relu_en;
         sb_in.bias  = in_first ? WIDE_W'(bias_in) : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q <= '0;
         for (int k = 0; k <= TD; k++) sb_q[k] <= '0;
      end else begin
         prod_q   <= prod_d;
         sb_q[0]  <= sb_in;
         for (int k = 1; k <= TD; k++) sb_q[k] <= sb_q[k-1];
      end
   end

   // ---------------- tree stages ----------------
   pe_adder_tree_p #(
      .N    (N_PE),
      .IN_W (PROD_W),
      .TD   (TD)
   ) u_tree (
      .clk    (clk),
      .rst_n  (rst_n),
      .data_i (prod_q),
      .sum_o  (tree_sum)
   );

   // ---------------- stage A: accumulator ----------------
   assign sb_a  = sb_q[TD];
   assign acc_d = (sb_a.first ? ACC_W'(sb_a.bias) : acc_q) + ACC_W'(tree_sum);

   // A closing beat hands the finished sum to stage O and restarts the accumulator from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q      <= '0;
         res_q      <= '0;
         res_vld_q  <= 1'b0;
         res_relu_q <= 1'b0;
      end else begin
         res_vld_q <= sb_a.valid & sb_a.last;
         if (sb_a.valid) begin
            if (sb_a.last) begin
               acc_q      <= '0;
               res_q      <= acc_d;
               res_relu_q <= sb_a.relu;
            end else begin
               acc_q <= acc_d;
            end
         end
      end
   end

   // ---------------- stage O: ReLU then saturation ----------------
   always_comb begin
      relu_v = WIDE_W'(res_q);
      if (res_relu_q && res_q[ACC_W-1]) relu_v = '0;
      clamp_v = sat_signed(relu_v, OUT_W);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         ofm_q       <= '0;
         sat_q       <= 1'b0;
      end else begin
         out_valid_q <= res_vld_q;
         if (res_vld_q) begin
            ofm_q <= clamp_v[OUT_W-1:0];
            sat_q <= (clamp_v != relu_v);
         end
      end
   end

   assign out_valid = out_valid_q;
   assign ofm_out   = ofm_q;
   assign sat_flag  = sat_q;

   // Upper bits are sign copies by construction.
   assign unused_hi = ^{sb_a.bias[WIDE_W-1:ACC_W], clamp_v[WIDE_W-1:OUT_W]};

endmodule

// File: tb/tb_pe_array_acc.sv
// Directed bench for pe_array_acc (N_PE=9, IN_W=8, ACC_W=32, OUT_W=20, LAT=7).
// Output pulses are logged with their cycle stamp and compared against hand-computed results.
module tb_pe_array_acc;
   import pe_arr_pkg::*;

   localparam int N_PE  = 9;
   localparam int IN_W  = 8;
   localparam int ACC_W = 32;
   localparam int OUT_W = 20;
   localparam int LAT   = 7;
   localparam int VW    = N_PE * IN_W;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    in_valid = 1'b0;
   logic                    in_first = 1'b0;
   logic                    in_last = 1'b0;
   logic [VW-1:0]           ifm_in = '0;
   logic [VW-1:0]           wgt_in = '0;
   logic signed [ACC_W-1:0] bias_in = '0;
   logic                    relu_en = 1'b0;
   logic                    out_valid;
   logic signed [OUT_W-1:0] ofm_out;
   logic                    sat_flag;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int cyc;
      int ofm;
      bit sat;
   } out_t;
   out_t outq[$];

   typedef struct {
      logic [VW-1:0] ifm;
      logic [VW-1:0] wgt;
      int            bias;
      bit            relu;
      int            exp_ofm;
      bit            exp_sat;
   } vec_t;

   pe_array_acc #(
      .IN_W  (IN_W),
      .N_PE  (N_PE),
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_first  (in_first),
      .in_last   (in_last),
      .ifm_in    (ifm_in),
      .wgt_in    (wgt_in),
      .bias_in   (bias_in),
      .relu_en   (relu_en),
      .out_valid (out_valid),
      .ofm_out   (ofm_out),
      .sat_flag  (sat_flag)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (out_valid) outq.push_back('{cyc: cyc, ofm: int'(ofm_out), sat: sat_flag});
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [VW-1:0] splat(input int v);
      logic [VW-1:0] r;
      for (int i = 0; i < N_PE; i++) r[i*IN_W +: IN_W] = v[IN_W-1:0];
      return r;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic beat(input logic f, input logic l, input logic [VW-1:0] ifm,
                       input logic [VW-1:0] wgt, input int bias, input logic relu,
                       output int c);
      @(negedge clk);
      in_valid = 1'b1;
      in_first = f;
      in_last  = l;
      ifm_in   = ifm;
      wgt_in   = wgt;
      bias_in  = bias;
      relu_en  = relu;
      c = cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_first = 1'b0;
         in_last  = 1'b0;
      end
   endtask

   task automatic expect_out(input string name, input int exp_cyc, input int exp_ofm,
                             input bit exp_sat);
      out_t o;
      if (outq.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: got no out_valid pulse expected one at cycle %0d", name, exp_cyc);
      end else begin
         o = outq.pop_front();
         check({name, ".cyc"}, o.cyc, exp_cyc);
         check({name, ".ofm"}, o.ofm, exp_ofm);
         check({name, ".sat"}, o.sat, exp_sat);
      end
   endtask

   task automatic expect_none(input string name);
      check({name, ".extra_pulses"}, outq.size(), 0);
      outq.delete();
   endtask

   initial begin
      vec_t          vecs[13];
      logic [VW-1:0] ramp_i, ramp_w;
      int            c0, c1, c2, c3;

      for (int i = 0; i < N_PE; i++) begin
         ramp_i[i*IN_W +: IN_W] = IN_W'(i + 1);
         ramp_w[i*IN_W +: IN_W] = IN_W'(i - 4);
      end

      vecs[0]  = '{splat(1),    splat(2),    5,        1'b0, 23,      1'b0};
      vecs[1]  = '{splat(1),    splat(-1),   0,        1'b1, 0,       1'b0};
      vecs[2]  = '{splat(1),    splat(-1),   0,        1'b0, -9,      1'b0};
      vecs[3]  = '{splat(-128), splat(-128), 0,        1'b0, 147456,  1'b0};
      vecs[4]  = '{splat(-128), splat(127),  -1000,    1'b0, -147304, 1'b0};
      vecs[5]  = '{splat(1),    splat(1),    524278,   1'b0, 524287,  1'b0};
      vecs[6]  = '{splat(1),    splat(1),    524279,   1'b0, 524287,  1'b1};
      vecs[7]  = '{splat(1),    splat(1),    -524297,  1'b0, -524288, 1'b0};
      vecs[8]  = '{splat(1),    splat(1),    -524298,  1'b0, -524288, 1'b1};
      vecs[9]  = '{splat(1),    splat(1),    -524298,  1'b1, 0,       1'b0};
      vecs[10] = '{splat(5),    splat(7),    3,        1'b1, 318,     1'b0};
      vecs[11] = '{ramp_i,      ramp_w,      0,        1'b0, 60,      1'b0};
      vecs[12] = '{splat(0),    splat(0),    1000000,  1'b0, 524287,  1'b1};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst.out_valid", out_valid, 0);
      check("rst.ofm_out", ofm_out, 0);
      check("rst.sat_flag", sat_flag, 0);
      rst_n = 1'b1;
      idle(2);
      check("rst_release.out_valid", out_valid, 0);
      expect_none("rst_release");

      // Single-pass windows from the table
      for (int i = 0; i < 13; i++) begin
         beat(1'b1, 1'b1, vecs[i].ifm, vecs[i].wgt, vecs[i].bias, vecs[i].relu, c0);
         idle(LAT + 3);
         expect_out($sformatf("vec%0d", i), c0 + LAT, vecs[i].exp_ofm, vecs[i].exp_sat);
         expect_none($sformatf("vec%0d", i));
      end

      // Three passes with a bubble; control/bias driven during the bubble must be ignored
      beat(1'b1, 1'b0, splat(3), splat(4), -10, 1'b0, c0);
      beat(1'b0, 1'b0, splat(3), splat(4), 777, 1'b0, c1);
      @(negedge clk);
      in_valid = 1'b0;
      in_first = 1'b1;
      in_last  = 1'b1;
      bias_in  = 999;
      beat(1'b0, 1'b1, splat(3), splat(4), 555, 1'b0, c2);
      idle(LAT + 3);
      expect_out("three_pass", c2 + LAT, 314, 1'b0);
      expect_none("three_pass");

      // Four passes saturating high, then low
      beat(1'b1, 1'b0, splat(-128), splat(-128), 0, 1'b0, c0);
      beat(1'b0, 1'b0, splat(-128), splat(-128), 0, 1'b0, c1);
      beat(1'b0, 1'b0, splat(-128), splat(-128), 0, 1'b0, c2);
      beat(1'b0, 1'b1, splat(-128), splat(-128), 0, 1'b0, c3);
      idle(LAT + 3);
      expect_out("sat_hi", c3 + LAT, 524287, 1'b1);
      expect_none("sat_hi");
      beat(1'b1, 1'b0, splat(-128), splat(127), 0, 1'b0, c0);
      beat(1'b0, 1'b0, splat(-128), splat(127), 0, 1'b0, c1);
      beat(1'b0, 1'b0, splat(-128), splat(127), 0, 1'b0, c2);
      beat(1'b0, 1'b1, splat(-128), splat(127), 0, 1'b0, c3);
      idle(LAT + 3);
      expect_out("sat_lo", c3 + LAT, -524288, 1'b1);
      expect_none("sat_lo");

      // Back-to-back single-pass windows
      beat(1'b1, 1'b1, splat(1), splat(1), 0, 1'b0, c0);
      beat(1'b1, 1'b1, splat(1), splat(1), 100, 1'b0, c1);
      idle(LAT + 3);
      expect_out("b2b_0", c0 + LAT, 9, 1'b0);
      expect_out("b2b_1", c1 + LAT, 109, 1'b0);
      expect_none("b2b");

      // in_first inside an open window discards the partial sum
      beat(1'b1, 1'b0, splat(1), splat(1), 1000, 1'b0, c0);
      beat(1'b0, 1'b0, splat(1), splat(1), 0, 1'b0, c1);
      beat(1'b1, 1'b1, splat(1), splat(1), 7, 1'b0, c2);
      idle(LAT + 3);
      expect_out("restart", c2 + LAT, 16, 1'b0);
      expect_none("restart");

      // A beat after a closed window without in_first accumulates from zero, no bias
      beat(1'b1, 1'b1, splat(1), splat(2), 5, 1'b0, c0);
      beat(1'b0, 1'b1, splat(1), splat(2), 4000, 1'b0, c1);
      idle(LAT + 3);
      expect_out("after_win_0", c0 + LAT, 23, 1'b0);
      expect_out("after_win_1", c1 + LAT, 18, 1'b0);
      expect_none("after_win");

      // Reset mid-window: partial sum already in the accumulator must vanish
      beat(1'b1, 1'b0, splat(1), splat(1), 50, 1'b0, c0);
      beat(1'b0, 1'b0, splat(1), splat(1), 0, 1'b0, c1);
      idle(LAT);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst.out_valid", out_valid, 0);
      check("midrst.ofm_out", ofm_out, 0);
      check("midrst.sat_flag", sat_flag, 0);
      rst_n = 1'b1;
      idle(LAT + 5);
      expect_none("midrst");
      beat(1'b0, 1'b1, splat(1), splat(2), 0, 1'b0, c0);
      idle(LAT + 3);
      expect_out("midrst_nofirst", c0 + LAT, 18, 1'b0);
      beat(1'b1, 1'b1, splat(1), splat(2), 5, 1'b0, c1);
      idle(LAT + 3);
      expect_out("midrst_fresh", c1 + LAT, 23, 1'b0);
      expect_none("midrst_fresh");

      check("pkg.pe_lat", pe_lat(N_PE), LAT);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
